operand_loader: RTL and testbench
=================================

OPERAND_LOADER -- requirements
Module: operand_loader

Interface
REQ-001 Parameter DEBOUNCE_CYCLES, default 16, is the consecutive stable cycles needed to accept a button level change (range 2..65535).
REQ-002 clk  input  1  single system clock; all state updates on its rising edge.
REQ-003 rst_n  input  1  reset, asynchronous assert, active-low.
REQ-004 btn  input  1  raw push-button level, bouncy, asynchronous to clk.
REQ-005 sw  input  4  nibble value to load.
REQ-006 ack  input  1  consumer accepts the completed operand pair.
REQ-007 a  output  8  operand A.
REQ-008 b  output  8  operand B.
REQ-009 valid  output  1  both operands complete and unacknowledged.
REQ-010 nxt  output  2  nibble the next press loads: 0=A lo, 1=A hi, 2=B lo, 3=B hi.
REQ-011 press  output  1  one-cycle pulse per accepted press.

Function
REQ-012 Debounce: a 16-bit counter shall increment while btn differs from the debounced level and clear to 0 when it matches.
REQ-013 When the counter reaches DEBOUNCE_CYCLES-1 with btn still different, the debounced level shall toggle and the counter shall clear.
REQ-014 press shall pulse for exactly one cycle, in the cycle after the debounced level goes 0->1; a release shall produce no pulse.
REQ-015 FSM states: A_LO, A_HI, B_LO, B_HI, DONE; nxt shall equal the state encoding 0..3 and shall read 3 in DONE.
REQ-016 On press in A_LO: a[3:0]<=sw, go A_HI; in A_HI: a[7:4]<=sw, go B_LO; in B_LO: b[3:0]<=sw, go B_HI; in B_HI: b[7:4]<=sw, go DONE.
REQ-017 A nibble write shall be visible on a/b one clock after press is high; sw is sampled in the press cycle.
REQ-018 valid shall be 1 exactly while in DONE.
REQ-019 In DONE, ack=1 shall return the FSM to A_LO and drop valid the next cycle; a and b shall keep their values until overwritten.
REQ-020 A press in DONE shall be ignored: no register change, press still pulses.
REQ-021 ack outside DONE shall be ignored.
REQ-022 press and ack in the same DONE cycle: ack wins, the press is dropped, and the next state is A_LO.
REQ-023 Bounce shorter than DEBOUNCE_CYCLES in either direction shall produce no press and no state change.

Reset
REQ-024 While rst_n=0: a=0, b=0, valid=0, nxt=0, press=0, FSM=A_LO, debounced level=0, counter=0.
REQ-025 Reset mid-load shall discard partial operands; btn held high through deassertion counts as a press only after DEBOUNCE_CYCLES stable cycles.

Configuration
REQ-026 Macro OPERAND_LOADER_BTN_SYNC_EN defined: btn shall pass through a two-flop synchronizer (reset to 0) before the debouncer, adding 2 cycles to press latency.
REQ-027 Macro undefined: btn shall feed the debouncer directly; all other behaviour is unchanged.

Structure
REQ-028 Package operand_loader_pkg shall hold the state enum (A_LO..DONE), NIBBLE_W=4 and OPERAND_W=8.
REQ-029 Debounce plus edge detect shall be a sub-module btn_debounce (ports clk, rst_n, raw, level, rise; parameter DEBOUNCE_CYCLES).

Verification (DEBOUNCE_CYCLES=4, macro undefined unless noted)
REQ-030 Clean presses with sw=5,A,3,C in turn -> a=0xA5, b=0xC3, valid=1, nxt=3 after the fourth press; ack -> valid=0, nxt=0, a/b unchanged.
REQ-031 btn glitches high for 1, 2 and 3 cycles -> no press, nxt stays 0; 4-cycle high -> exactly one press pulse.
REQ-032 Fifth press in DONE with sw=F -> a=0xA5, b=0xC3 unchanged, valid stays 1.
REQ-033 ack and press in the same DONE cycle -> nxt=0, valid=0, a/b unchanged.
REQ-034 rst_n pulsed low after two nibbles are loaded -> a=0, b=0, nxt=0 immediately, without a clock edge.
REQ-035 With OPERAND_LOADER_BTN_SYNC_EN defined -> the press pulse appears exactly 2 cycles later than in REQ-031.

Source files
------------

// File: rtl/operand_loader_pkg.sv
// ---------------------------------------------------------------------------
// operand_loader_pkg
//   Shared types and widths for the operand loader.
//   - state_t   : loader FSM states, A_LO..B_HI encoded 0..3 so the low two
//                 bits double as the "next nibble" index; DONE sits above.
//   - NIBBLE_W  : width of one switch nibble.
//   - OPERAND_W : width of each assembled operand.
//   - CNT_W     : width of the debounce stability counter.
//   - nxt_of()  : maps a state to the nibble index the next press loads.
// ---------------------------------------------------------------------------
package operand_loader_pkg;

  localparam int NIBBLE_W  = 4;
  localparam int OPERAND_W = 8;
  localparam int CNT_W     = 16;

  typedef enum logic [2:0] {
    A_LO = 3'd0,
    A_HI = 3'd1,
    B_LO = 3'd2,
    B_HI = 3'd3,
    DONE = 3'd4
  } state_t;

  // DONE has no nibble of its own; it reports the last slot (B hi).
  function automatic logic [1:0] nxt_of(input state_t s);
    logic [2:0] enc;
    enc = s;
    if (s == DONE) return 2'd3;
    return enc[1:0];
  endfunction

endpackage

// File: rtl/operand_loader_btn_debounce.sv
// ---------------------------------------------------------------------------
// btn_debounce
//   Stability-counter debouncer with rising-edge pulse.
//   The counter runs while raw disagrees with the accepted level and clears
//   whenever they agree; once raw has disagreed for DEBOUNCE_CYCLES
//   consecutive rising edges the level flips.
//
//   Parameters
//     DEBOUNCE_CYCLES : consecutive stable cycles to accept a change (2..65535)
//   Ports
//     clk   in   system clock
//     rst_n in   async active-low reset
//     raw   in   button level (already synchronised if required)
//     level out  debounced level
//     rise  out  one-cycle pulse in the cycle after level goes 0->1
// ---------------------------------------------------------------------------
module btn_debounce
  import operand_loader_pkg::*;
#(
  parameter int DEBOUNCE_CYCLES = 16
) (
  input  logic clk,
  input  logic rst_n,
  input  logic raw,
  output logic level,
  output logic rise
);

  localparam logic [CNT_W-1:0] TC = CNT_W'(DEBOUNCE_CYCLES - 1);

  logic [CNT_W-1:0] cnt;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt   <= '0;
      level <= 1'b0;
      rise  <= 1'b0;
    end else begin
      rise <= 1'b0;
      if (raw != level) begin
        if (cnt == TC) begin
          cnt   <= '0;
          level <= ~level;
          // Only a 0->1 acceptance is a press; releases stay silent.
          rise  <= ~level;
        end else begin
          cnt <= cnt + 1'b1;
        end
      end else begin
        cnt <= '0;
      end
    end
  end

endmodule

// File: rtl/operand_loader.sv
// ---------------------------------------------------------------------------
// operand_loader
//   Builds two 8-bit operands from four button presses, one 4-bit switch
//   nibble per press (A lo, A hi, B lo, B hi), then holds them as valid
//   until the consumer acknowledges.
//
//   Build option
//     OPERAND_LOADER_BTN_SYNC_EN : when defined, btn goes through a two-flop
//                                  synchroniser (reset 0) ahead of the
//                                  debouncer, adding two cycles of press
//                                  latency. Undefined: btn feeds the
//                                  debouncer directly.
//
//   Parameters
//     DEBOUNCE_CYCLES : consecutive stable cycles to accept a btn change
//   Ports
//     clk   in   system clock
//     rst_n in   async active-low reset
//     btn   in   raw, bouncy push-button level
//     sw    in   [3:0] nibble to load
//     ack   in   consumer accepts the operand pair (only honoured in DONE)
//     a     out  [7:0] operand A
//     b     out  [7:0] operand B
//     valid out  both operands complete and unacknowledged
//     nxt   out  [1:0] nibble the next press loads (0=A lo .. 3=B hi)
//     press out  one-cycle pulse per accepted press
//
//   state | meaning
//   ------+-------------------------------------------
//   A_LO  | waiting for press to load a[3:0]
//   A_HI  | waiting for press to load a[7:4]
//   B_LO  | waiting for press to load b[3:0]
//   B_HI  | waiting for press to load b[7:4]
//   DONE  | pair complete, valid high, presses ignored
// ---------------------------------------------------------------------------
module operand_loader
  import operand_loader_pkg::*;
#(
  parameter int DEBOUNCE_CYCLES = 16
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 btn,
  input  logic [NIBBLE_W-1:0]  sw,
  input  logic                 ack,
  output logic [OPERAND_W-1:0] a,
  output logic [OPERAND_W-1:0] b,
  output logic                 valid,
  output logic [1:0]           nxt,
  output logic                 press
);

  logic   btn_db_in;
  logic   level_unused;
  state_t state;

`ifdef OPERAND_LOADER_BTN_SYNC_EN
  logic [1:0] btn_sync;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      btn_sync <= 2'b00;
    end else begin
      btn_sync <= {btn_sync[0], btn};
    end
  end

  assign btn_db_in = btn_sync[1];
`else
  assign btn_db_in = btn;
`endif

  // The debounced level itself is not needed here; only its rising edge is.
  btn_debounce #(
    .DEBOUNCE_CYCLES (DEBOUNCE_CYCLES)
  ) u_btn_debounce (
    .clk   (clk),
    .rst_n (rst_n),
    .raw   (btn_db_in),
    .level (level_unused),
    .rise  (press)
  );

  // valid and nxt are registered alongside state so they change on the same
  // edge as the state they describe.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= A_LO;
      a     <= '0;
      b     <= '0;
      valid <= 1'b0;
      nxt   <= nxt_of(A_LO);
    end else begin
      case (state)
        A_LO: begin
          if (press) begin
            a[NIBBLE_W-1:0] <= sw;
            state           <= A_HI;
            nxt             <= nxt_of(A_HI);
          end
        end
        A_HI: begin
          if (press) begin
            a[OPERAND_W-1:NIBBLE_W] <= sw;
            state                   <= B_LO;
            nxt                     <= nxt_of(B_LO);
          end
        end
        B_LO: begin
          if (press) begin
            b[NIBBLE_W-1:0] <= sw;
            state           <= B_HI;
            nxt             <= nxt_of(B_HI);
          end
        end
        B_HI: begin
          if (press) begin
            b[OPERAND_W-1:NIBBLE_W] <= sw;
            state                   <= DONE;
            valid                   <= 1'b1;
            nxt                     <= nxt_of(DONE);
          end
        end
        DONE: begin
          // ack takes priority; a press arriving here is simply dropped.
          if (ack) begin
            state <= A_LO;
            valid <= 1'b0;
            nxt   <= nxt_of(A_LO);
          end
        end
        default: begin
          state <= A_LO;
          valid <= 1'b0;
          nxt   <= nxt_of(A_LO);
        end
      endcase
    end
  end

endmodule

// File: tb/tb_operand_loader.sv
// ---------------------------------------------------------------------------
// tb_operand_loader
//   Self-checking bench for operand_loader with DEBOUNCE_CYCLES=4.
//   Expected register states are queued when a press is driven and compared
//   one clock after the DUT's press pulse. Press latency expectations follow
//   OPERAND_LOADER_BTN_SYNC_EN.
// ---------------------------------------------------------------------------
module tb_operand_loader;

  localparam int DC = 4;
`ifdef OPERAND_LOADER_BTN_SYNC_EN
  localparam int SYNC_LAT = 2;
`else
  localparam int SYNC_LAT = 0;
`endif
  localparam int SETTLE = DC + 2 + SYNC_LAT;

  logic       clk   = 1'b0;
  logic       rst_n = 1'b0;
  logic       btn   = 1'b0;
  logic       ack   = 1'b0;
  logic [3:0] sw    = 4'h0;
  logic [7:0] a;
  logic [7:0] b;
  logic       valid;
  logic [1:0] nxt;
  logic       press;

  typedef struct {
    logic [7:0] a;
    logic [7:0] b;
    logic [1:0] nxt;
    logic       valid;
  } exp_t;

  typedef struct {
    logic [3:0] sw;
    exp_t       e;
  } vec_t;

  exp_t sb[$];
  exp_t sb_e;
  vec_t tbl[9];

  int  n_cmp     = 0;
  int  n_bad     = 0;
  int  cyc       = 0;
  int  press_cyc = -1;
  int  press_cnt = 0;
  bit  check_next = 1'b0;

  operand_loader #(
    .DEBOUNCE_CYCLES (DC)
  ) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .btn   (btn),
    .sw    (sw),
    .ack   (ack),
    .a     (a),
    .b     (b),
    .valid (valid),
    .nxt   (nxt),
    .press (press)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string name, input int act, input int req);
    n_cmp++;
    if (act != req) begin
      n_bad++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", name, act, req, $time);
    end
  endtask

  // Scoreboard: every press pulse must match a queued expectation, checked
  // one clock after the pulse once the nibble write has landed.
  always @(negedge clk) begin
    if (check_next) begin
      sb_e = sb.pop_front();
      chk("sb_a",     int'(a),     int'(sb_e.a));
      chk("sb_b",     int'(b),     int'(sb_e.b));
      chk("sb_nxt",   int'(nxt),   int'(sb_e.nxt));
      chk("sb_valid", int'(valid), int'(sb_e.valid));
      check_next = 1'b0;
    end
    if (press) begin
      press_cnt++;
      press_cyc = cyc;
      if (sb.size() == 0) chk("unexpected_press", 1, 0);
      else check_next = 1'b1;
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic press_pulse(input logic [3:0] v);
    sw  = v;
    btn = 1'b1;
    repeat (SETTLE) step();
    btn = 1'b0;
    repeat (SETTLE) step();
  endtask

  task automatic glitch(input int n);
    btn = 1'b1;
    repeat (n) step();
    btn = 1'b0;
    repeat (SETTLE) step();
  endtask

  task automatic apply_vec(input int i);
    sb.push_back(tbl[i].e);
    press_pulse(tbl[i].sw);
    chk($sformatf("vec%0d_consumed", i), sb.size(), 0);
    if (sb.size() != 0) sb.delete();
  endtask

  initial begin
    int c0;
    int pc0;

    tbl[0] = '{4'h5, '{8'h05, 8'h00, 2'd1, 1'b0}};
    tbl[1] = '{4'hA, '{8'hA5, 8'h00, 2'd2, 1'b0}};
    tbl[2] = '{4'h3, '{8'hA5, 8'h03, 2'd3, 1'b0}};
    tbl[3] = '{4'hC, '{8'hA5, 8'hC3, 2'd3, 1'b1}};
    tbl[4] = '{4'hF, '{8'hA5, 8'hC3, 2'd3, 1'b1}};
    tbl[5] = '{4'h1, '{8'hA1, 8'hC3, 2'd1, 1'b0}};
    tbl[6] = '{4'h2, '{8'h21, 8'hC3, 2'd2, 1'b0}};
    tbl[7] = '{4'h4, '{8'h21, 8'hC4, 2'd3, 1'b0}};
    tbl[8] = '{4'h6, '{8'h21, 8'h64, 2'd3, 1'b1}};

    // Reset state
    repeat (2) step();
    chk("rst_a",     int'(a),     0);
    chk("rst_b",     int'(b),     0);
    chk("rst_nxt",   int'(nxt),   0);
    chk("rst_valid", int'(valid), 0);
    chk("rst_press", int'(press), 0);
    rst_n = 1'b1;
    step();

    // First load plus an ignored press in DONE
    for (int i = 0; i <= 4; i++) apply_vec(i);

    // ack in DONE
    ack = 1'b1;
    step();
    ack = 1'b0;
    chk("ack_valid", int'(valid), 0);
    chk("ack_nxt",   int'(nxt),   0);
    chk("ack_a",     int'(a),     'hA5);
    chk("ack_b",     int'(b),     'hC3);

    // Second load with an ack outside DONE in the middle
    apply_vec(5);
    ack = 1'b1;
    step();
    ack = 1'b0;
    step();
    chk("ack_ign_nxt",   int'(nxt),   1);
    chk("ack_ign_valid", int'(valid), 0);
    chk("ack_ign_a",     int'(a),     'hA1);
    for (int i = 6; i <= 8; i++) apply_vec(i);

    // ack and press in the same DONE cycle
    sw = 4'hF;
    sb.push_back('{8'h21, 8'h64, 2'd0, 1'b0});
    btn = 1'b1;
    repeat (DC + SYNC_LAT) step();
    chk("coinc_press", int'(press), 1);
    ack = 1'b1;
    step();
    ack = 1'b0;
    repeat (2) step();
    btn = 1'b0;
    repeat (SETTLE) step();
    chk("coinc_nxt",   int'(nxt),   0);
    chk("coinc_valid", int'(valid), 0);
    chk("coinc_a",     int'(a),     'h21);
    chk("coinc_b",     int'(b),     'h64);
    chk("coinc_consumed", sb.size(), 0);
    if (sb.size() != 0) sb.delete();

    // Short high glitches: no press
    sw = 4'h7;
    for (int n = 1; n < DC; n++) begin
      pc0 = press_cnt;
      glitch(n);
      chk($sformatf("glitch%0d_press", n), press_cnt - pc0, 0);
      chk($sformatf("glitch%0d_nxt", n), int'(nxt), 0);
    end

    // Exactly DC cycles high: one press, latency DC (+ sync)
    pc0 = press_cnt;
    press_cyc = -1;
    sb.push_back('{8'h27, 8'h64, 2'd1, 1'b0});
    c0 = cyc;
    glitch(DC);
    chk("min_press_count", press_cnt - pc0, 1);
    chk("min_press_latency", press_cyc - c0, DC + SYNC_LAT);
    chk("min_consumed", sb.size(), 0);
    if (sb.size() != 0) sb.delete();

    // Press, then a short low glitch while held: only one press
    pc0 = press_cnt;
    sw = 4'h9;
    sb.push_back('{8'h97, 8'h64, 2'd2, 1'b0});
    btn = 1'b1;
    repeat (SETTLE) step();
    btn = 1'b0;
    repeat (DC - 1) step();
    btn = 1'b1;
    repeat (DC - 1) step();
    btn = 1'b0;
    repeat (SETTLE) step();
    chk("rel_glitch_press_count", press_cnt - pc0, 1);
    chk("rel_glitch_nxt", int'(nxt), 2);

    // Reset mid-load clears immediately; btn held through release
    btn = 1'b1;
    sw  = 4'h6;
    rst_n = 1'b0;
    #2;
    chk("midrst_a",     int'(a),     0);
    chk("midrst_b",     int'(b),     0);
    chk("midrst_nxt",   int'(nxt),   0);
    chk("midrst_valid", int'(valid), 0);
    step();
    rst_n = 1'b1;
    c0 = cyc;
    press_cyc = -1;
    pc0 = press_cnt;
    sb.push_back('{8'h06, 8'h00, 2'd1, 1'b0});
    repeat (SETTLE) step();
    btn = 1'b0;
    repeat (SETTLE) step();
    chk("postrst_press_count", press_cnt - pc0, 1);
    chk("postrst_latency", press_cyc - c0, DC + SYNC_LAT);

    chk("sb_drained", sb.size(), 0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
